// File: rtl/exec_stage.sv
// Execute stage: ALU with shift, result forwarding, load-use detection and branch/jump
// resolution, feeding a registered EX/MEM bundle.
module exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] reg1data,
  input  logic [15:0] reg2data,
  input  logic [2:0]  ALU_func,
  input  logic [1:0]  shamt,
  input  logic [6:0]  iVal,
  input  logic [15:0] PC,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic        use_rs2,
  input  logic [2:0]  rd,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        bne,
  input  logic        jmp,
  input  logic        stall_in,
  output logic [15:0] res,
  output logic [15:0] st_data,
  output logic [2:0]  rd_out,
  output logic        regwrite_out,
  output logic        memread_out,
  output logic        memwrite_out,
  output logic        valid_out,
  output logic        flush,
  output logic [15:0] target_pc,
  output logic        ld_hazard
);

  logic [15:0] imm;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] alu_out;
  logic [15:0] res_d;
  logic [15:0] target_d;
  logic        fwd_ok;
  logic        taken;
  logic        capture;

  assign imm = {{9{iVal[6]}}, iVal};

  // A loaded value is not available yet, so loads never forward; they stall instead.
  assign fwd_ok = valid_out & regwrite_out & ~memread_out;
  assign op_a   = (fwd_ok && (rd_out == rs1)) ? res : reg1data;
  assign op_b   = (fwd_ok && use_rs2 && (rd_out == rs2)) ? res : reg2data;

  assign ld_hazard = valid_in & valid_out & memread_out &
                     ((rd_out == rs1) | (use_rs2 & (rd_out == rs2)));

  assign capture = valid_in & ~stall_in & ~ld_hazard & ~flush;

  always_comb begin
    alu_out = 16'h0000;
    case (ALU_func)
      3'b000:  alu_out = op_a + op_b;
      3'b001:  alu_out = op_a - op_b;
      3'b010:  alu_out = op_a & op_b;
      3'b011:  alu_out = ~(op_a & op_b);
      3'b100:  alu_out = op_a | op_b;
      3'b101:  alu_out = op_a ^ op_b;
      3'b110:  alu_out = op_b;
      default: alu_out = op_a;
    endcase
  end

  always_comb begin
    res_d    = alu_out << shamt;
    target_d = PC + imm;
    taken    = jmp | (bne & (op_a != op_b));
    if (memRead || memWrite) res_d = op_a + imm;
    if (jmp) target_d = op_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res          <= 16'h0000;
      st_data      <= 16'h0000;
      rd_out       <= 3'd0;
      regwrite_out <= 1'b0;
      memread_out  <= 1'b0;
      memwrite_out <= 1'b0;
      valid_out    <= 1'b0;
      flush        <= 1'b0;
      target_pc    <= 16'h0000;
    end else begin
      // Flush is a one-cycle pulse even if a stall begins right after the capture.
      flush <= capture & taken;
      if (capture) begin
        res          <= res_d;
        st_data      <= op_b;
        rd_out       <= rd;
        regwrite_out <= regWrite & (rd != 3'd0);
        memread_out  <= memRead;
        memwrite_out <= memWrite;
        valid_out    <= 1'b1;
        if (taken) target_pc <= target_d;
      end else if (!stall_in) begin
        regwrite_out <= 1'b0;
        memread_out  <= 1'b0;
        memwrite_out <= 1'b0;
        valid_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed-vector bench for exec_stage with hand-computed expectations.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] reg1data, reg2data, PC;
  logic [2:0]  ALU_func;
  logic [1:0]  shamt;
  logic [6:0]  iVal;
  logic [2:0]  rs1, rs2, rd;
  logic        use_rs2, regWrite, memRead, memWrite, bne, jmp, stall_in;
  logic [15:0] res, st_data, target_pc;
  logic [2:0]  rd_out;
  logic        regwrite_out, memread_out, memwrite_out, valid_out, flush, ld_hazard;

  int n_vec = 0;
  int n_err = 0;

  exec_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .reg1data(reg1data), .reg2data(reg2data),
    .ALU_func(ALU_func), .shamt(shamt), .iVal(iVal), .PC(PC), .rs1(rs1), .rs2(rs2),
    .use_rs2(use_rs2), .rd(rd), .regWrite(regWrite), .memRead(memRead),
    .memWrite(memWrite), .bne(bne), .jmp(jmp), .stall_in(stall_in), .res(res),
    .st_data(st_data), .rd_out(rd_out), .regwrite_out(regwrite_out),
    .memread_out(memread_out), .memwrite_out(memwrite_out), .valid_out(valid_out),
    .flush(flush), .target_pc(target_pc), .ld_hazard(ld_hazard)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid_in = 0; reg1data = 0; reg2data = 0; ALU_func = 0; shamt = 0; iVal = 0; PC = 0;
    rs1 = 0; rs2 = 0; use_rs2 = 0; rd = 0; regWrite = 0; memRead = 0; memWrite = 0;
    bne = 0; jmp = 0; stall_in = 0;
  endtask

  task automatic alu_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] sh, input logic [2:0] s1, input logic [2:0] s2,
                        input logic u2, input logic [2:0] d);
    clear_in();
    valid_in = 1; ALU_func = f; reg1data = a; reg2data = b; shamt = sh;
    rs1 = s1; rs2 = s2; use_rs2 = u2; rd = d; regWrite = 1;
  endtask

  initial begin
    clear_in();
    rst = 0;
    tick();
    tick();
    check_eq("rst_valid", {15'd0, valid_out}, 16'h0);
    check_eq("rst_res", res, 16'h0);
    check_eq("rst_flush", {15'd0, flush}, 16'h0);
    check_eq("rst_tpc", target_pc, 16'h0);
    check_eq("rst_ldhz", {15'd0, ld_hazard}, 16'h0);

    // ADD with shift, first capture after reset release
    rst = 1;
    alu_op(3'b000, 16'h0003, 16'h0004, 2'b01, 3'd3, 3'd4, 1'b1, 3'd2);
    tick();
    check_eq("add_res", res, 16'h000E);
    check_eq("add_rd", {13'd0, rd_out}, 16'd2);
    check_eq("add_rw", {15'd0, regwrite_out}, 16'h1);
    check_eq("add_valid", {15'd0, valid_out}, 16'h1);

    // Forwarding into A, then into B
    alu_op(3'b000, 16'h0005, 16'h0000, 2'b00, 3'd4, 3'd5, 1'b1, 3'd2);
    tick();
    check_eq("fwd_prod", res, 16'h0005);
    alu_op(3'b001, 16'h0000, 16'h0001, 2'b00, 3'd2, 3'd1, 1'b0, 3'd3);
    tick();
    check_eq("fwd_a_sub", res, 16'h0004);
    alu_op(3'b101, 16'h00FF, 16'h0000, 2'b00, 3'd5, 3'd3, 1'b1, 3'd4);
    tick();
    check_eq("fwd_b_xor", res, 16'h00FB);

    // NAND with shift to r0: write suppressed
    alu_op(3'b011, 16'h00F0, 16'h0F0F, 2'b11, 3'd6, 3'd7, 1'b1, 3'd0);
    tick();
    check_eq("nand_res", res, 16'hFFF8);
    check_eq("r0_rw", {15'd0, regwrite_out}, 16'h0);

    // Pass B, shift truncation
    alu_op(3'b110, 16'h0000, 16'h4001, 2'b10, 3'd6, 3'd7, 1'b1, 3'd5);
    tick();
    check_eq("passb_res", res, 16'h0004);

    // Load-use hazard
    alu_op(3'b000, 16'h0010, 16'h0000, 2'b00, 3'd6, 3'd7, 1'b0, 3'd1);
    memRead = 1; iVal = 7'h7F;
    tick();
    check_eq("lw_res", res, 16'h000F);
    check_eq("lw_mr", {15'd0, memread_out}, 16'h1);
    alu_op(3'b000, 16'h0100, 16'h0001, 2'b00, 3'd1, 3'd2, 1'b1, 3'd6);
    #1;
    check_eq("ldhz_on", {15'd0, ld_hazard}, 16'h1);
    tick();
    check_eq("ldhz_bubble", {15'd0, valid_out}, 16'h0);
    check_eq("ldhz_off", {15'd0, ld_hazard}, 16'h0);
    tick();
    check_eq("ldhz_cap_valid", {15'd0, valid_out}, 16'h1);
    check_eq("ldhz_cap_res", res, 16'h0101);

    // Store: address and data
    alu_op(3'b000, 16'h0100, 16'hBEEF, 2'b00, 3'd0, 3'd0, 1'b1, 3'd0);
    regWrite = 0; memWrite = 1; iVal = 7'h05;
    tick();
    check_eq("sw_res", res, 16'h0105);
    check_eq("sw_data", st_data, 16'hBEEF);
    check_eq("sw_mw", {15'd0, memwrite_out}, 16'h1);

    // Taken bne, next input squashed
    alu_op(3'b000, 16'h0001, 16'h0002, 2'b00, 3'd0, 3'd0, 1'b1, 3'd0);
    regWrite = 0; bne = 1; PC = 16'h0020; iVal = 7'h04;
    tick();
    check_eq("bne_flush", {15'd0, flush}, 16'h1);
    check_eq("bne_tpc", target_pc, 16'h0024);
    alu_op(3'b000, 16'h0009, 16'h0000, 2'b00, 3'd0, 3'd0, 1'b0, 3'd7);
    tick();
    check_eq("bne_flush_end", {15'd0, flush}, 16'h0);
    check_eq("squash_valid", {15'd0, valid_out}, 16'h0);

    // Not-taken bne
    alu_op(3'b000, 16'h0003, 16'h0003, 2'b00, 3'd0, 3'd0, 1'b1, 3'd0);
    regWrite = 0; bne = 1; PC = 16'h0040; iVal = 7'h04;
    tick();
    check_eq("bne_nt_flush", {15'd0, flush}, 16'h0);
    check_eq("bne_nt_tpc", target_pc, 16'h0024);
    check_eq("bne_nt_valid", {15'd0, valid_out}, 16'h1);

    // Jump, then stall rises: flush one cycle, outputs frozen
    alu_op(3'b111, 16'h1234, 16'h0000, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0);
    regWrite = 0; jmp = 1; bne = 1; PC = 16'h0050; iVal = 7'h01;
    tick();
    check_eq("jmp_flush", {15'd0, flush}, 16'h1);
    check_eq("jmp_tpc", target_pc, 16'h1234);
    alu_op(3'b000, 16'h0007, 16'h0007, 2'b00, 3'd0, 3'd0, 1'b0, 3'd3);
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stall_flush", {15'd0, flush}, 16'h0);
      check_eq("stall_res", res, 16'h1234);
      check_eq("stall_valid", {15'd0, valid_out}, 16'h1);
    end

    // Async reset mid-stall
    rst = 0;
    #1;
    check_eq("arst_valid", {15'd0, valid_out}, 16'h0);
    check_eq("arst_res", res, 16'h0);
    check_eq("arst_tpc", target_pc, 16'h0);
    check_eq("arst_rd", {13'd0, rd_out}, 16'h0);
    tick();
    rst = 1;
    alu_op(3'b000, 16'h0002, 16'h0002, 2'b00, 3'd0, 3'd0, 1'b0, 3'd1);
    tick();
    check_eq("post_rst_res", res, 16'h0004);
    check_eq("post_rst_valid", {15'd0, valid_out}, 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
